// File: rtl/polar_pkg.sv
// polar_pkg: shared LLR width default and saturation helpers for the polar decoder datapath
package polar_pkg;

    localparam int LLR_WIDTH = 6;

    // Largest magnitude representable in a symmetric w-bit LLR
    function automatic int llr_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Clamp to [-llr_max(w), +llr_max(w)]; the most negative code is never produced
    function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
        logic signed [31:0] m;
        m = llr_max(w);
        return v > m ? m : (v < -m ? -m : v);
    endfunction

endpackage

// File: rtl/llr_sat.sv
// llr_sat: combinational round-half-up arithmetic shift and symmetric clamp of one channel LLR
//   din  - signed IN_WIDTH channel LLR
//   dout - signed WIDTH decoder LLR
module llr_sat #(
    parameter int IN_WIDTH = 8,
    parameter int WIDTH    = polar_pkg::LLR_WIDTH,
    parameter int SHIFT    = 2
) (
    input  logic signed [IN_WIDTH-1:0] din,
    output logic signed [WIDTH-1:0]    dout
);

    // Rounding constant is 2^(SHIFT-1), or 0 when no shift is applied
    localparam logic signed [IN_WIDTH:0] RND = (IN_WIDTH + 1)'((1 << SHIFT) >> 1);

    logic signed [IN_WIDTH:0] t;

    // One extra bit keeps in_llr + RND from overflowing
    assign t    = ((IN_WIDTH + 1)'(din) + RND) >>> SHIFT;
    assign dout = WIDTH'(polar_pkg::sat(32'(t), WIDTH));

endmodule

// File: rtl/polar_llr_loader.sv
// polar_llr_loader: ping-pong channel LLR frame loader feeding the stage-n L inputs
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid/in_ready    - serial channel sample handshake; in_llr sample, in_last end of codeword
//   frame_valid/ready    - parallel frame handshake; frame_llr element i at [i*WIDTH +: WIDTH]
//   err_len              - one-cycle pulse after a frame-length violation
module polar_llr_loader
    import polar_pkg::*;
#(
    parameter int WIDTH    = LLR_WIDTH,
    parameter int IN_WIDTH = 8,
    parameter int N        = 8,
    parameter int SHIFT    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_llr,
    input  logic                in_last,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic [N*WIDTH-1:0]  frame_llr,
    output logic                err_len
);

    localparam int IW = $clog2(N);

    logic [N*WIDTH-1:0]      bank [2];
    logic [1:0]              full;
    logic [IW-1:0]           idx;
    logic                    wr_bank;
    logic                    rd_bank;
    logic signed [WIDTH-1:0] q;
    logic                    acc;
    logic                    commit;
    logic                    early;
    logic                    consume;

    llr_sat #(.IN_WIDTH(IN_WIDTH), .WIDTH(WIDTH), .SHIFT(SHIFT)) u_sat (
        .din  (in_llr),
        .dout (q)
    );

    assign in_ready    = rst_n & ~full[wr_bank];
    assign acc         = in_valid & in_ready;
    assign commit      = acc & (idx == IW'(N - 1));
    assign early       = acc & in_last & ~commit;
    assign frame_valid = full[rd_bank];
    assign consume     = frame_valid & frame_ready;
    assign frame_llr   = frame_valid ? bank[rd_bank] : '0;

    // A presented bank is full, so it is never the write target and stays stable.
    // Commit and consume always hit different banks, so both updates can coexist.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank[0] <= '0;
            bank[1] <= '0;
            full    <= '0;
            idx     <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            err_len <= 1'b0;
        end else begin
            err_len <= (commit & ~in_last) | early;
            idx     <= (commit | early) ? '0 : (acc ? idx + 1'b1 : idx);
            if (acc)
                bank[wr_bank][int'(idx)*WIDTH +: WIDTH] <= q;
            if (commit) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (consume) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_polar_llr_loader.sv
// tb_polar_llr_loader: self-checking bench against a queue-based frame model
module tb_polar_llr_loader;

    localparam int W  = 6;
    localparam int IW = 8;
    localparam int N  = 8;
    localparam int SH = 2;

    typedef struct {
        int x;
        int q;
    } qvec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_last = 1'b0;
    logic                 frame_ready = 1'b0;
    logic signed [IW-1:0] in_llr = '0;
    logic                 in_ready;
    logic                 frame_valid;
    logic                 err_len;
    logic [N*W-1:0]       frame_llr;

    int                   n_chk = 0;
    int                   n_fail = 0;
    logic [N*W-1:0]       fq [$];
    logic signed [W-1:0]  cur [$];
    logic                 exp_err = 1'b0;
    logic                 last_acc = 1'b0;
    qvec_t                qtab [8];

    always #5 clk = ~clk;

    polar_llr_loader #(.WIDTH(W), .IN_WIDTH(IW), .N(N), .SHIFT(SH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_llr      (in_llr),
        .in_last     (in_last),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_llr   (frame_llr),
        .err_len     (err_len)
    );

    // Reference quantizer: floor((x + 2^(SH-1)) / 2^SH), clamped to +-31
    function automatic logic signed [W-1:0] quant(input int x);
        int t;
        int d;
        d = 1 << SH;
        t = x + d / 2;
        t = t >= 0 ? t / d : -((d - 1 - t) / d);
        t = t > 31 ? 31 : (t < -31 ? -31 : t);
        return W'(t);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare outputs against the model, then advance the model across the edge
    task automatic step();
        logic er;
        logic acc;
        logic cons;
        logic [N*W-1:0] f;
        @(negedge clk);
        er = rst_n && fq.size() < 2;
        check("in_ready", 64'(in_ready), 64'(er));
        check("frame_valid", 64'(frame_valid), 64'(fq.size() > 0));
        check("frame_llr", 64'(frame_llr), fq.size() > 0 ? 64'(fq[0]) : 64'd0);
        check("err_len", 64'(err_len), 64'(exp_err));
        acc = in_valid & er;
        cons = (fq.size() > 0) & frame_ready;
        last_acc = acc;
        @(posedge clk);
        #1;
        exp_err = 1'b0;
        if (!rst_n) begin
            fq.delete();
            cur.delete();
        end else begin
            if (cons) void'(fq.pop_front());
            if (acc) begin
                cur.push_back(quant(int'(in_llr)));
                if (cur.size() == N) begin
                    for (int i = 0; i < N; i++) f[i*W +: W] = cur[i];
                    fq.push_back(f);
                    exp_err = !in_last;
                    cur.delete();
                end else if (in_last) begin
                    exp_err = 1'b1;
                    cur.delete();
                end
            end
        end
    endtask

    task automatic send(input int x, input logic last);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        in_llr = IW'(x);
        in_last = last;
        for (int k = 0; k < 50 && !got; k++) begin
            step();
            got = last_acc;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: sample %0d not accepted within 50 cycles", x);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_frame(input int base, input logic with_last);
        for (int i = 0; i < N; i++) send(base + 4 * i, with_last && i == N - 1);
    endtask

    task automatic drain();
        frame_ready = 1'b1;
        repeat (3) step();
        frame_ready = 1'b0;
    endtask

    initial begin
        qtab = '{'{127, 31}, '{-128, -31}, '{5, 1}, '{-6, -1}, '{6, 2}, '{0, 0}, '{0, 0}, '{0, 0}};
        repeat (2) step();
        check("reset_fv", 64'(frame_valid), 64'd0);
        check("reset_err", 64'(err_len), 64'd0);
        rst_n = 1'b1;

        // Quantizer corners against constant table
        for (int i = 0; i < N; i++) send(qtab[i].x, i == N - 1);
        check("quant_fv", 64'(frame_valid), 64'd1);
        for (int i = 0; i < N; i++)
            check($sformatf("quant_%0d", i), 64'(signed'(frame_llr[i*W +: W])), 64'(qtab[i].q));
        drain();

        // Single frame, held 20 cycles before consumption
        send_frame(0, 1'b1);
        check("single_fv", 64'(frame_valid), 64'd1);
        for (int i = 0; i < N; i++)
            check($sformatf("single_%0d", i), 64'(frame_llr[i*W +: W]), 64'(i));
        repeat (20) step();
        drain();

        // Ping-pong stall: third frame waits until one bank is consumed
        send_frame(40, 1'b1);
        send_frame(-60, 1'b1);
        in_valid = 1'b1;
        in_llr = 8'sd12;
        repeat (3) step();
        check("stall_ready", 64'(in_ready), 64'd0);
        check("stall_acc", 64'(last_acc), 64'd0);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        check("stall_fv", 64'(frame_valid), 64'd1);
        send_frame(12, 1'b1);
        drain();

        // Early last, then a valid frame, then a frame with no last
        for (int i = 0; i < 5; i++) send(i * 8, i == 4);
        check("early_err", 64'(err_len), 64'd1);
        check("early_fv", 64'(frame_valid), 64'd0);
        send_frame(3, 1'b1);
        check("after_early_fv", 64'(frame_valid), 64'd1);
        drain();
        send_frame(-30, 1'b0);
        check("nolast_err", 64'(err_len), 64'd1);
        check("nolast_fv", 64'(frame_valid), 64'd1);
        drain();

        // Consume and commit in the same cycle
        send_frame(20, 1'b1);
        for (int i = 0; i < N - 1; i++) send(-4 * i, 1'b0);
        frame_ready = 1'b1;
        send(-100, 1'b1);
        frame_ready = 1'b0;
        check("simul_fv", 64'(frame_valid), 64'd1);
        check("simul_ready", 64'(in_ready), 64'd1);
        drain();

        // Reset in the middle of a frame
        for (int i = 0; i < 4; i++) send(i, 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst_n = 1'b1;
        check("rst_fv", 64'(frame_valid), 64'd0);
        send_frame(1, 1'b1);
        check("rst_frame_fv", 64'(frame_valid), 64'd1);
        drain();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_llr = IW'($urandom);
            in_last = ($urandom_range(0, 9) == 0);
            frame_ready = ($urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/polar_llr_loader.md
Name: polar_llr_loader

Overview:
- Channel-side front end of the SCAN polar decoder. It sits directly upstream of the rightmost PE stage and feeds the channel L messages (stage-n L inputs).
- Accepts a serial stream of wide channel LLRs with a valid/ready handshake, scales and saturates each one to the decoder LLR width, and assembles N values into a frame.
- Double-buffered (ping-pong), so the next codeword loads while the current one is being decoded.
- Presents a complete frame as a flat parallel word with its own valid/ready handshake.

Parameters:
- WIDTH, 6, decoder LLR width; signed two's complement, same as the PE datapath.
- IN_WIDTH, 8, channel LLR input width; signed; must be >= WIDTH.
- N, 8, code length (LLRs per frame); power of two, >= 2.
- SHIFT, 2, arithmetic right-shift (with rounding) applied before saturation; 0 to SHIFT < IN_WIDTH allowed.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  channel sample valid.
- in_ready  out  1  loader can accept a sample.
- in_llr  in  IN_WIDTH  signed channel LLR.
- in_last  in  1  marks the final sample of a codeword.
- frame_valid  out  1  a complete frame is presented.
- frame_ready  in  1  decoder consumes the frame.
- frame_llr  out  N*WIDTH  element i at bits [i*WIDTH +: WIDTH], where i is arrival order.
- err_len  out  1  one-cycle pulse on a frame-length violation.

Behaviour:
- Reset: clk and rst_n as named above. With rst_n low at a rising edge:
  - both banks empty, bank contents cleared to 0;
  - write index 0; write bank 0, read bank 0;
  - frame_valid 0, err_len 0.
  - in_ready is forced to 0 combinationally while rst_n is low. Any sample presented during reset is ignored.
- Quantize (combinational, per sample):
  - t = (in_llr + 2^(SHIFT-1)) >>> SHIFT, computed in IN_WIDTH+1 bits. When SHIFT=0, t = in_llr.
  - Clamp t to the symmetric range [-(2^(WIDTH-1)-1), +(2^(WIDTH-1)-1)]. The value -2^(WIDTH-1) is never produced.
- Accept:
  - Accept occurs when in_valid & in_ready.
  - in_ready = rst_n & !full[wr_bank].
  - The quantized value is written to bank[wr_bank][idx] at the edge; idx increments.
- Frame commit (accept with idx == N-1):
  - full[wr_bank] is set, idx returns to 0, wr_bank toggles.
  - If in_last is 0 on this sample, err_len pulses the next cycle; the frame is still committed.
- Early last (accept with in_last=1 and idx < N-1):
  - The partial frame is discarded: idx returns to 0, the bank stays empty, wr_bank is unchanged.
  - err_len pulses the next cycle.
- Read side:
  - frame_valid = full[rd_bank].
  - frame_llr = bank[rd_bank] while frame_valid is high, otherwise all-zero.
  - frame_llr is stable for as long as frame_valid is high.
  - On frame_valid & frame_ready: full[rd_bank] is cleared and rd_bank toggles at that edge.
- Latency: frame_valid rises in the first cycle after the edge that accepted sample N-1. There is no combinational path from in_* to frame_*.
- Back-to-back frames: the second bank fills while the first is presented. With both banks full, in_ready = 0.
- Simultaneous consume and commit in the same cycle: both take effect. The freed bank raises in_ready from the next cycle (registered state).
- Throughput: sustains 1 sample/cycle indefinitely if frame_ready is held high.
- Reset mid-frame or mid-presentation: everything is dropped and the block returns to the reset state. No err_len pulse is generated.

Decomposition:
- Shared package polar_pkg:
  - default WIDTH;
  - function llr_max(WIDTH) = 2^(WIDTH-1)-1;
  - a saturation function reused by the f1/f2 datapath.
- One sub-module, llr_sat: purely combinational shift, round and clamp, parameterised by IN_WIDTH, WIDTH and SHIFT. Instantiated once, on the write path only.
- Banks, indices and the full flags stay in polar_llr_loader.

Test Plan (WIDTH=6, IN_WIDTH=8, SHIFT=2, N=8):
- Quantizer corners: inputs 127, -128, 5, -6, 6, 0 -> stored as 31, -31, 1, -1, 2, 0.
- Single frame: samples 0,4,8,...,28 back-to-back, in_last on the 8th, frame_ready=0.
  - frame_valid rises 1 cycle after the 8th accept.
  - frame_llr elements = 0..7.
  - frame_llr holds for 20 cycles until frame_ready.
- Ping-pong stall: load 3 frames with frame_ready=0.
  - in_ready drops after frame 2 commits; frame 3 stalls.
  - Pulse frame_ready once: frame 1 leaves, frame 2 is presented, in_ready returns the next cycle, frame 3 completes.
- Length errors:
  - in_last on sample 5 -> err_len pulse, nothing presented, the next 8 samples form a valid frame.
  - 8 samples with no in_last -> err_len pulse, frame presented.
- Simultaneous: frame_ready asserted in the same cycle that bank 2's final sample is accepted.
  - Frame 1 leaves, frame 2 is presented next cycle, no sample is lost.
- Reset mid-frame: rst_n low for 1 cycle after 4 samples -> frame_valid 0, in_ready 0 during reset; a fresh 8-sample frame afterwards is correct.
